map_update_arbiter: RTL and testbench
=====================================

Name: map_update_arbiter

Overview:
- Owns the 8x18 card map (144 cells x 6-bit card type) and the per-cell selection bits that the card drawing datapath reads.
- Shares write access between two requesters: local game logic (l_*) and remote player link (r_*).
- Serialises their operations with round-robin arbitration.
- Optionally commits changes only during vertical blanking, so a frame never shows a half-updated map.

Parameters:
- NUM_CELLS, 144, number of map cells (8 rows x 18 columns).
- CELL_W, 6, card type width per cell.
- VBLANK_START, 480, first v_cnt value treated as blanking.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- v_cnt  in  10  VGA vertical counter, same clock domain.
- l_req  in  1  local request.
- l_op  in  2  local op: 0 WRITE_CARD, 1 TOGGLE_SEL, 2 CLEAR_SEL, 3 CLEAR_ALL.
- l_pos  in  8  local target cell, x + y*18.
- l_card  in  6  local card type for WRITE_CARD.
- l_done  out  1  one-cycle completion pulse to local.
- r_req, r_op, r_pos, r_card, r_done  same as l_*, for the remote requester.
- err  out  1  one-cycle pulse, coincident with done, when the op was rejected.
- busy  out  1  high whenever state != IDLE.
- map  out  864  flattened map; cell i at bits [i*6+5 -: 6].
- sel_card  out  144  selection bit per cell; cell i at bit i.

Behaviour:
- Reset:
  - map = 0, sel_card = 0.
  - l_done, r_done, err = 0; busy = 0.
  - State = IDLE; round-robin pointer favours local.
- FSM states: IDLE, WAIT_VB, EXEC, CLEAR.
- IDLE:
  - If any req is high at edge n, pick the winner. Both high: pointer winner; one high: that one.
  - Latch winner id, op, pos and card; go to WAIT_VB.
  - Pointer moves to the non-winner.
- WAIT_VB: go to EXEC when the commit condition holds (see Optional Feature). Otherwise stay.
- EXEC, single cycle:
  - WRITE_CARD: map[pos] <= card.
  - TOGGLE_SEL: sel_card[pos] flips.
  - CLEAR_SEL: sel_card <= 0 in one cycle.
  - For all three: winner's done = 1 for that cycle, then IDLE.
  - CLEAR_ALL: go to CLEAR with cell counter = 0.
- CLEAR:
  - Each cycle clears map[counter] and sel_card[counter], then increments the counter.
  - The cycle clearing cell 143 also pulses done and returns to IDLE; 144 cycles total.
  - Once started, CLEAR runs to completion even if blanking ends.
- Latency, commit condition true: req at edge n -> write and done pulse at edge n+2.
- Invalid position:
  - pos >= 144 on WRITE_CARD or TOGGLE_SEL: no state change.
  - done and err pulse together in EXEC.
  - pos is ignored for CLEAR_SEL and CLEAR_ALL.
- Handshake:
  - Operands are sampled only at grant; req may drop after grant and done is still issued.
  - A req still high in IDLE after done counts as a new request.
  - The losing requester holds req and waits; it is never dropped.
- Reset mid-operation (including mid-CLEAR): immediate return to reset values; a partial clear is not resumed; no done is issued.
- Outputs map and sel_card are registers, never combinational from inputs.

Optional Feature:
- Macro: MAP_VBLANK_SYNC_EN.
- Defined: commit condition is v_cnt >= VBLANK_START; writes wait in WAIT_VB until blanking.
- Undefined: commit condition is constant true; v_cnt is unused; WAIT_VB always lasts one cycle.

Decomposition:
- Shared package holds:
  - Op encodings: OP_WRITE_CARD=0, OP_TOGGLE_SEL=1, OP_CLEAR_SEL=2, OP_CLEAR_ALL=3.
  - MAP_ROWS=8, MAP_COLS=18, NUM_CELLS, CELL_W.
  - VBLANK_START.
  - FSM state encodings.
- One natural sub-module: rr_arbiter2 (2-way round-robin grant plus pointer update).

Test Plan:
- Macro off; l_req with WRITE_CARD, pos=37, card=6'h15 -> map[227:222]=15h and l_done pulses exactly 2 edges after req sampled; err=0.
- l_req and r_req together after reset, both TOGGLE_SEL pos=5 -> local served first, then remote; sel_card[5] ends 0; two done pulses, local first; next simultaneous pair serves remote first.
- r_req WRITE_CARD pos=150 -> map unchanged; r_done and err pulse in the same cycle.
- CLEAR_ALL after filling cells 0..143 with 6'h3F and all sel bits -> map=0 and sel_card=0 after 144 CLEAR cycles; busy high throughout; one done.
- Macro on; v_cnt=100, WRITE_CARD pos=0 -> busy, map unchanged until v_cnt reaches 480; write and done on the next EXEC edge.
- rst asserted at CLEAR counter=70 -> next edge all outputs zero, state IDLE, no done pulse.

Source files
------------

// File: rtl/map_update_arbiter_pkg.sv
// rtl/map_update_arbiter_pkg.sv - shared constants, op/state encodings and command type
// Used by map_update_arbiter (optional MAP_VBLANK_SYNC_EN) and rr_arbiter2.
package map_update_arbiter_pkg;

  localparam int MAP_ROWS     = 8;
  localparam int MAP_COLS     = 18;
  localparam int NUM_CELLS    = MAP_ROWS * MAP_COLS;
  localparam int CELL_W       = 6;
  localparam int MAP_W        = NUM_CELLS * CELL_W;
  localparam int POS_W        = 8;
  localparam int VBLANK_START = 480;

  localparam logic [1:0] OP_WRITE_CARD = 2'd0;
  localparam logic [1:0] OP_TOGGLE_SEL = 2'd1;
  localparam logic [1:0] OP_CLEAR_SEL  = 2'd2;
  localparam logic [1:0] OP_CLEAR_ALL  = 2'd3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_VB = 2'd1;
  localparam logic [1:0] ST_EXEC    = 2'd2;
  localparam logic [1:0] ST_CLEAR   = 2'd3;

  // Operands captured at grant; id 0 is local, 1 is remote.
  typedef struct packed {
    logic              id;
    logic [1:0]        op;
    logic [POS_W-1:0]  pos;
    logic [CELL_W-1:0] card;
  } cmd_t;

  function automatic logic pos_valid(input logic [POS_W-1:0] pos);
    return int'(pos) < NUM_CELLS;
  endfunction

endpackage

// File: rtl/map_update_arbiter_rr_arbiter2.sv
// rtl/map_update_arbiter_rr_arbiter2.sv - two-way round-robin grant and pointer update
// ptr = 0 favours local, ptr = 1 favours remote; after a grant the pointer favours the loser.
module rr_arbiter2 (
  input  logic req_l,
  input  logic req_r,
  input  logic ptr,
  output logic gnt_valid,
  output logic gnt_r,
  output logic ptr_next
);

  always_comb begin
    gnt_valid = req_l | req_r;
    gnt_r     = req_r & (~req_l | ptr);
    ptr_next  = gnt_valid ? ~gnt_r : ptr;
  end

endmodule

// File: rtl/map_update_arbiter.sv
// rtl/map_update_arbiter.sv - round-robin serialised updates of the 8x18 card map and selection bits
// MAP_VBLANK_SYNC_EN: when defined, commits wait until v_cnt >= VBLANK_START.
module map_update_arbiter
  import map_update_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           v_cnt,
  input  logic                 l_req,
  input  logic [1:0]           l_op,
  input  logic [POS_W-1:0]     l_pos,
  input  logic [CELL_W-1:0]    l_card,
  output logic                 l_done,
  input  logic                 r_req,
  input  logic [1:0]           r_op,
  input  logic [POS_W-1:0]     r_pos,
  input  logic [CELL_W-1:0]    r_card,
  output logic                 r_done,
  output logic                 err,
  output logic                 busy,
  output logic [MAP_W-1:0]     map,
  output logic [NUM_CELLS-1:0] sel_card
);

  logic [1:0]           state_q, state_d;
  logic                 ptr_q, ptr_d;
  cmd_t                 cmd_q, cmd_d;
  logic [POS_W-1:0]     cnt_q, cnt_d;
  logic [MAP_W-1:0]     map_q, map_d;
  logic [NUM_CELLS-1:0] sel_q, sel_d;
  logic                 l_done_q, l_done_d;
  logic                 r_done_q, r_done_d;
  logic                 err_q, err_d;

  logic gnt_valid, gnt_r, ptr_next;
  logic commit;
  logic fin;

  rr_arbiter2 u_rr (
    .req_l     (l_req),
    .req_r     (r_req),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_r     (gnt_r),
    .ptr_next  (ptr_next)
  );

`ifdef MAP_VBLANK_SYNC_EN
  assign commit = (v_cnt >= 10'(VBLANK_START));
`else
  logic unused_v_cnt;
  assign unused_v_cnt = ^v_cnt;
  assign commit       = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    map_d   = map_q;
    sel_d   = sel_q;
    err_d   = 1'b0;
    fin     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          cmd_d.id   = gnt_r;
          cmd_d.op   = gnt_r ? r_op   : l_op;
          cmd_d.pos  = gnt_r ? r_pos  : l_pos;
          cmd_d.card = gnt_r ? r_card : l_card;
          ptr_d      = ptr_next;
          state_d    = ST_WAIT_VB;
        end
      end

      ST_WAIT_VB: begin
        if (commit) state_d = ST_EXEC;
      end

      ST_EXEC: begin
        state_d = ST_IDLE;
        fin     = 1'b1;
        case (cmd_q.op)
          OP_WRITE_CARD: begin
            if (pos_valid(cmd_q.pos)) map_d[int'(cmd_q.pos)*CELL_W +: CELL_W] = cmd_q.card;
            else                      err_d = 1'b1;
          end
          OP_TOGGLE_SEL: begin
            if (pos_valid(cmd_q.pos)) sel_d[cmd_q.pos] = ~sel_q[cmd_q.pos];
            else                      err_d = 1'b1;
          end
          OP_CLEAR_SEL: sel_d = '0;
          default: begin
            // CLEAR_ALL defers its done until the sweep reaches the last cell.
            fin     = 1'b0;
            cnt_d   = '0;
            state_d = ST_CLEAR;
          end
        endcase
      end

      ST_CLEAR: begin
        map_d[int'(cnt_q)*CELL_W +: CELL_W] = '0;
        sel_d[cnt_q]                        = 1'b0;
        cnt_d                               = cnt_q + 8'd1;
        if (cnt_q == 8'(NUM_CELLS - 1)) begin
          fin     = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    l_done_d = fin & ~cmd_q.id;
    r_done_d = fin &  cmd_q.id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 1'b0;
      cmd_q    <= '0;
      cnt_q    <= '0;
      map_q    <= '0;
      sel_q    <= '0;
      l_done_q <= 1'b0;
      r_done_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cmd_q    <= cmd_d;
      cnt_q    <= cnt_d;
      map_q    <= map_d;
      sel_q    <= sel_d;
      l_done_q <= l_done_d;
      r_done_q <= r_done_d;
      err_q    <= err_d;
    end
  end

  assign l_done   = l_done_q;
  assign r_done   = r_done_q;
  assign err      = err_q;
  assign busy     = (state_q != ST_IDLE);
  assign map      = map_q;
  assign sel_card = sel_q;

endmodule

// File: tb/tb_map_update_arbiter.sv
// tb/tb_map_update_arbiter.sv - scoreboard bench for map_update_arbiter
// Directed ops push expected completions; a negedge monitor pops and compares on each done.
module tb_map_update_arbiter;
  import map_update_arbiter_pkg::*;

`ifdef MAP_VBLANK_SYNC_EN
  localparam logic [9:0] V_DEFAULT = 10'd500;
`else
  localparam logic [9:0] V_DEFAULT = 10'd100;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [9:0]           v_cnt;
  logic                 l_req, r_req;
  logic [1:0]           l_op, r_op;
  logic [POS_W-1:0]     l_pos, r_pos;
  logic [CELL_W-1:0]    l_card, r_card;
  logic                 l_done, r_done, err, busy;
  logic [MAP_W-1:0]     map;
  logic [NUM_CELLS-1:0] sel_card;

  map_update_arbiter dut (
    .clk(clk), .rst(rst), .v_cnt(v_cnt),
    .l_req(l_req), .l_op(l_op), .l_pos(l_pos), .l_card(l_card), .l_done(l_done),
    .r_req(r_req), .r_op(r_op), .r_pos(r_pos), .r_card(r_card), .r_done(r_done),
    .err(err), .busy(busy), .map(map), .sel_card(sel_card)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit                   id;
    bit                   e;
    int                   cyc;
    logic [MAP_W-1:0]     m;
    logic [NUM_CELLS-1:0] s;
  } exp_t;

  exp_t                 sb[$];
  exp_t                 got_e;
  logic [MAP_W-1:0]     mm;
  logic [NUM_CELLS-1:0] ms;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [MAP_W-1:0] got, input logic [MAP_W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic bit model_apply(input logic [1:0] op, input logic [POS_W-1:0] pos,
                                     input logic [CELL_W-1:0] card);
    case (op)
      OP_WRITE_CARD: begin
        if (int'(pos) >= 144) return 1'b1;
        mm[int'(pos)*6 +: 6] = card;
      end
      OP_TOGGLE_SEL: begin
        if (int'(pos) >= 144) return 1'b1;
        ms[pos] = ~ms[pos];
      end
      OP_CLEAR_SEL: ms = '0;
      default: begin
        mm = '0;
        ms = '0;
      end
    endcase
    return 1'b0;
  endfunction

  task automatic push_exp(input bit side, input bit e, input int c);
    exp_t x;
    x.id = side; x.e = e; x.cyc = c; x.m = mm; x.s = ms;
    sb.push_back(x);
  endtask

  task automatic set_req(input bit side, input bit v, input logic [1:0] op,
                         input logic [POS_W-1:0] pos, input logic [CELL_W-1:0] card);
    if (side) begin r_req = v; r_op = op; r_pos = pos; r_card = card; end
    else      begin l_req = v; l_op = op; l_pos = pos; l_card = card; end
  endtask

  // Holds the request until this side's done, then drops it before the next IDLE sample.
  task automatic wait_done(input bit side, output bit busy_ok);
    int  n = 0;
    bit  d = 1'b0;
    busy_ok = 1'b1;
    while (!d && n < 400) begin
      @(negedge clk);
      n++;
      d = side ? r_done : l_done;
      if (!d && !busy) busy_ok = 1'b0;
    end
    if (side) r_req = 1'b0; else l_req = 1'b0;
    if (!d) chk("op_timeout", 1'b0, 1'b1);
  endtask

  task automatic do_op(input bit side, input logic [1:0] op, input logic [POS_W-1:0] pos,
                       input logic [CELL_W-1:0] card);
    bit e, bok;
    @(negedge clk);
    e = model_apply(op, pos, card);
    push_exp(side, e, cyc + ((op == OP_CLEAR_ALL) ? 147 : 3));
    set_req(side, 1'b1, op, pos, card);
    wait_done(side, bok);
    if (op == OP_CLEAR_ALL) chk("busy_during_clear", bok, 1'b1);
  endtask

  // Both requesters raised in the same cycle; first_r selects who the pointer should favour.
  task automatic do_pair(input bit first_r, input logic [1:0] op, input logic [POS_W-1:0] pos,
                         input logic [CELL_W-1:0] l_c, input logic [CELL_W-1:0] r_c);
    bit e, b0, b1;
    @(negedge clk);
    if (first_r) begin
      e = model_apply(op, pos, r_c); push_exp(1'b1, e, cyc + 3);
      e = model_apply(op, pos, l_c); push_exp(1'b0, e, cyc + 6);
    end else begin
      e = model_apply(op, pos, l_c); push_exp(1'b0, e, cyc + 3);
      e = model_apply(op, pos, r_c); push_exp(1'b1, e, cyc + 6);
    end
    set_req(1'b0, 1'b1, op, pos, l_c);
    set_req(1'b1, 1'b1, op, pos, r_c);
    fork
      wait_done(1'b0, b0);
      wait_done(1'b1, b1);
    join
  endtask

  always @(negedge clk) begin
    if (l_done || r_done || err) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {l_done, r_done, err}, 3'b000);
      end else begin
        got_e = sb.pop_front();
        chk("done_id", {l_done, r_done}, got_e.id ? 2'b01 : 2'b10);
        chk("err", err, got_e.e);
        if (got_e.cyc >= 0) chk("done_cycle", cyc, got_e.cyc);
        chk("map", map, got_e.m);
        chk("sel_card", sel_card, got_e.s);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1; v_cnt = V_DEFAULT;
    l_req = 0; l_op = 0; l_pos = 0; l_card = 0;
    r_req = 0; r_op = 0; r_pos = 0; r_card = 0;
    mm = '0; ms = '0;
    repeat (3) @(negedge clk);
    chk("reset_map", map, '0);
    chk("reset_sel", sel_card, '0);
    chk("reset_flags", {l_done, r_done, err, busy}, 4'b0000);
    rst = 1'b0;

    // After reset local wins; toggling pos 5 twice leaves it clear.
    do_pair(1'b0, OP_TOGGLE_SEL, 8'd5, 6'h00, 6'h00);
    chk("pair1_sel5", sel_card[5], 1'b0);

    // Single local write; remote was last winner so pointer now favours local, then moves to remote.
    do_op(1'b0, OP_WRITE_CARD, 8'd37, 6'h15);
    chk("cell37", map[227:222], 6'h15);

    // Pointer favours remote: remote writes 0B first, local overwrites with 0A.
    do_pair(1'b1, OP_WRITE_CARD, 8'd10, 6'h0A, 6'h0B);
    chk("cell10", map[65:60], 6'h0A);

    do_op(1'b1, OP_WRITE_CARD, 8'd150, 6'h03);
    do_op(1'b0, OP_TOGGLE_SEL, 8'd200, 6'h00);
    do_op(1'b1, OP_WRITE_CARD, 8'd143, 6'h2C);
    do_op(1'b0, OP_TOGGLE_SEL, 8'd7, 6'h00);
    do_op(1'b1, OP_CLEAR_SEL, 8'd250, 6'h00);

    for (int i = 0; i < NUM_CELLS; i++) begin
      do_op(i[0], OP_WRITE_CARD, 8'(i), 6'h3F);
      do_op(~i[0], OP_TOGGLE_SEL, 8'(i), 6'h00);
    end
    chk("filled_map", map, {MAP_W{1'b1}});
    chk("filled_sel", sel_card, {NUM_CELLS{1'b1}});

    do_op(1'b1, OP_CLEAR_ALL, 8'd99, 6'h00);
    chk("cleared_map", map, '0);
    chk("cleared_sel", sel_card, '0);

`ifdef MAP_VBLANK_SYNC_EN
    v_cnt = 10'd100;
    @(negedge clk);
    void'(model_apply(OP_WRITE_CARD, 8'd0, 6'h22));
    push_exp(1'b0, 1'b0, -1);
    set_req(1'b0, 1'b1, OP_WRITE_CARD, 8'd0, 6'h22);
    @(negedge clk);
    l_req = 1'b0;
    repeat (10) @(negedge clk);
    chk("vb_busy_wait", busy, 1'b1);
    chk("vb_cell0_held", map[5:0], 6'h00);
    v_cnt = 10'd480;
    sb[sb.size()-1].cyc = cyc + 2;
    repeat (3) @(negedge clk);
    chk("vb_cell0", map[5:0], 6'h22);
    v_cnt = V_DEFAULT;
`endif

    do_op(1'b0, OP_WRITE_CARD, 8'd69, 6'h11);
    do_op(1'b1, OP_WRITE_CARD, 8'd100, 6'h2A);
    do_op(1'b0, OP_TOGGLE_SEL, 8'd100, 6'h00);

    // Reset while the sweep counter sits at 70: cells 0..69 cleared, 100 still intact.
    @(negedge clk);
    k = cyc;
    set_req(1'b0, 1'b1, OP_CLEAR_ALL, 8'd0, 6'h00);
    @(negedge clk);
    l_req = 1'b0;
    while (cyc < k + 73) @(negedge clk);
    chk("midclear_cell69", map[419:414], 6'h00);
    chk("midclear_cell100", map[605:600], 6'h2A);
    chk("midclear_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_map", map, '0);
    chk("rst_sel", sel_card, '0);
    chk("rst_flags", {l_done, r_done, err, busy}, 4'b0000);
    rst = 1'b0;
    mm = '0; ms = '0;
    repeat (160) @(negedge clk);
    chk("post_rst_idle", busy, 1'b0);

    do_pair(1'b0, OP_WRITE_CARD, 8'd1, 6'h05, 6'h06);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
